// File: rtl/mem_alu_sequencer.sv
// mem_alu_sequencer
// -----------------
// Command sequencer that sits directly upstream of the 32x8 register-file/ALU block.
// It accepts one instruction at a time over a valid/ready handshake and latches it.
// It then walks IDLE -> SETUP -> STROBE -> CAPTURE.
// During that walk it drives the memory address, data, strobes and ALU function select.
// At the end it captures load data or ALU flags.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   instr_valid/ready    instruction handshake (ready only in IDLE)
//   instr_op/addr/data   opcode, register address, store data
//   mem_address          register-file address (held SETUP..CAPTURE)
//   mem_data_input       register-file write data (held SETUP..CAPTURE)
//   mem_write_enable     one-cycle write strobe (STORE)
//   mem_read_enable      one-cycle read strobe (LOAD)
//   mem_output_data      register-file read data
//   alu_function_select  00 ADD, 01 SUB, 10 CMP, 11 INC
//   alu_result           ALU result, top bit is carry/borrow
//   flags                {cmp, negative, zero, carry}
//   rd_data/rd_valid     last LOAD result and its one-cycle pulse
//   err                  sticky illegal-opcode indicator
module mem_alu_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_input,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_output_data,
  output logic [1:0]        alu_function_select,
  input  logic [DATA_W:0]   alu_result,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_CMP   = 3'b101;
  localparam logic [2:0] OP_INC   = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE
  } state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_we;
  logic              r_re;
  logic [1:0]        r_fsel;
  logic [3:0]        r_flags;
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdValid;
  logic              r_err;

  logic              w_isAluLatched;
  logic              w_isAluIn;
  logic [1:0]        w_fselIn;
  logic [3:0]        w_aluFlags;

  // Classify the incoming opcode and translate ALU ops to the 2-bit select.
  always_comb begin
    w_isAluIn = 1'b0;
    w_fselIn  = r_fsel;
    case (instr_op)
      OP_ADD: begin w_isAluIn = 1'b1; w_fselIn = 2'b00; end
      OP_SUB: begin w_isAluIn = 1'b1; w_fselIn = 2'b01; end
      OP_CMP: begin w_isAluIn = 1'b1; w_fselIn = 2'b10; end
      OP_INC: begin w_isAluIn = 1'b1; w_fselIn = 2'b11; end
      default: begin w_isAluIn = 1'b0; w_fselIn = r_fsel; end
    endcase
  end

  // Flags derived from the settled ALU result of the latched operation.
  // The compare bit only survives a CMP; other ALU ops clear it.
  always_comb begin
    w_isAluLatched = (r_op == OP_ADD) || (r_op == OP_SUB) ||
                     (r_op == OP_CMP) || (r_op == OP_INC);
    w_aluFlags[0]  = alu_result[DATA_W];
    w_aluFlags[1]  = (alu_result[DATA_W-1:0] == '0);
    w_aluFlags[2]  = alu_result[DATA_W-1];
    w_aluFlags[3]  = (r_op == OP_CMP) & alu_result[0];
  end

  // Sequencer FSM with every output registered.
  // Strobes and rd_valid default low each cycle, so they can only ever be one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= OP_NOP;
      r_ready   <= 1'b1;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_fsel    <= 2'b00;
      r_flags   <= 4'b0000;
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_rdValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            if (instr_op == OP_ILL) begin
              r_err <= 1'b1;
            end else if (instr_op != OP_NOP) begin
              // Latch everything now so later input changes cannot leak in.
              r_op    <= instr_op;
              r_addr  <= instr_addr;
              r_data  <= instr_data;
              r_ready <= 1'b0;
              r_state <= S_SETUP;
              if (w_isAluIn) begin
                r_fsel <= w_fselIn;
              end
            end
          end
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          r_we    <= (r_op == OP_STORE);
          r_re    <= (r_op == OP_LOAD);
        end
        S_STROBE: begin
          // Read data and ALU result have had the whole STROBE cycle to settle.
          r_state <= S_CAPTURE;
          if (r_op == OP_LOAD) begin
            r_rdData  <= mem_output_data;
            r_rdValid <= 1'b1;
          end
          if (w_isAluLatched) begin
            r_flags <= w_aluFlags;
          end
        end
        S_CAPTURE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready         = r_ready;
  assign mem_address         = r_addr;
  assign mem_data_input      = r_data;
  assign mem_write_enable    = r_we;
  assign mem_read_enable     = r_re;
  assign alu_function_select = r_fsel;
  assign flags               = r_flags;
  assign rd_data             = r_rdData;
  assign rd_valid            = r_rdValid;
  assign err                 = r_err;

endmodule

// File: tb/tb_mem_alu_sequencer.sv
// tb_mem_alu_sequencer
// --------------------
// Directed and random instructions for mem_alu_sequencer.
// The bench keeps a small memory in front of the DUT.
// Expected values come from a plain reference model of the instruction set:
// an array of register contents, expected flags, function select and error bit.
module tb_mem_alu_sequencer;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_CMP   = 3'b101;
  localparam logic [2:0] OP_INC   = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [2:0]        instr_op = 3'b000;
  logic [ADDR_W-1:0] instr_addr = '0;
  logic [DATA_W-1:0] instr_data = '0;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_input;
  logic              mem_write_enable;
  logic              mem_read_enable;
  logic [DATA_W-1:0] mem_output_data;
  logic [1:0]        alu_function_select;
  logic [DATA_W:0]   alu_result = '0;
  logic [3:0]        flags;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              err;

  int nAssert = 0;
  int nFail = 0;
  int cycle = 0;
  int weCount = 0;
  int reCount = 0;
  int rvCount = 0;

  logic [DATA_W-1:0] benchMem [32];

  logic [DATA_W-1:0] refMem [32];
  logic [3:0]        refFlags = 4'b0000;
  logic [1:0]        refFsel = 2'b00;
  logic              refErr = 1'b0;
  logic [DATA_W-1:0] refRd = '0;

  mem_alu_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr_op            (instr_op),
    .instr_addr          (instr_addr),
    .instr_data          (instr_data),
    .mem_address         (mem_address),
    .mem_data_input      (mem_data_input),
    .mem_write_enable    (mem_write_enable),
    .mem_read_enable     (mem_read_enable),
    .mem_output_data     (mem_output_data),
    .alu_function_select (alu_function_select),
    .alu_result          (alu_result),
    .flags               (flags),
    .rd_data             (rd_data),
    .rd_valid            (rd_valid),
    .err                 (err)
  );

  always #5 clk = ~clk;

  // Register-file stand-in: asynchronous read, written on a strobed edge.
  assign mem_output_data = benchMem[mem_address];

  always @(posedge clk) begin
    cycle = cycle + 1;
    if (mem_write_enable) begin
      benchMem[mem_address] = mem_data_input;
      weCount = weCount + 1;
    end
    if (mem_read_enable) reCount = reCount + 1;
    if (rd_valid) rvCount = rvCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert = nAssert + 1;
    assert (obs === exp) else begin
      nFail = nFail + 1;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // The two strobes must never be high together.
  always @(negedge clk) begin
    checkOutput("strobeExclusive", 32'(mem_write_enable & mem_read_enable), 32'd0);
  end

  // Instruction-level reference: what each opcode does to architectural state.
  task automatic refApply(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input logic [DATA_W:0] res);
    case (op)
      OP_STORE: refMem[addr] = data;
      OP_LOAD:  refRd = refMem[addr];
      OP_ADD, OP_SUB, OP_CMP, OP_INC: begin
        refFlags[0] = res[DATA_W];
        refFlags[1] = (res[DATA_W-1:0] == 0);
        refFlags[2] = res[DATA_W-1];
        refFlags[3] = (op == OP_CMP) && res[0];
        if (op == OP_ADD) refFsel = 2'b00;
        else if (op == OP_SUB) refFsel = 2'b01;
        else if (op == OP_CMP) refFsel = 2'b10;
        else refFsel = 2'b11;
      end
      OP_ILL:  refErr = 1'b1;
      default: ;
    endcase
  endtask

  task automatic resetRef();
    refFlags = 4'b0000;
    refFsel  = 2'b00;
    refErr   = 1'b0;
    refRd    = '0;
  endtask

  // Presents one instruction (called at a negedge or just after a posedge).
  // It returns after the accepting edge.
  // Unless the caller keeps valid asserted, the fields are then scrambled,
  // which exercises the latching of op/addr/data.
  task automatic applyStimulus(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input bit keep,
                               output int acceptCycle);
    int waited;
    instr_op    = op;
    instr_addr  = addr;
    instr_data  = data;
    instr_valid = 1'b1;
    waited = 0;
    if (!instr_ready || $time % 10 != 0) begin
      @(negedge clk);
      while (!instr_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
    end
    checkOutput("acceptWait", 32'(waited >= 20), 32'd0);
    @(posedge clk);
    #1;
    acceptCycle = cycle;
    if (!keep) begin
      instr_valid = 1'b0;
      instr_op    = 3'($urandom);
      instr_addr  = ADDR_W'($urandom);
      instr_data  = DATA_W'($urandom);
    end
  endtask

  // Issues one instruction and checks the cycle-by-cycle behaviour and final state.
  task automatic runInstr(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input logic [DATA_W:0] res);
    int acc;
    bit isLoad;
    bit isStore;
    alu_result = res;
    refApply(op, addr, data, res);
    applyStimulus(op, addr, data, 1'b0, acc);
    isLoad  = (op == OP_LOAD);
    isStore = (op == OP_STORE);
    if (op == OP_NOP || op == OP_ILL) begin
      @(negedge clk);
      checkOutput("singleReady", 32'(instr_ready), 32'd1);
      checkOutput("singleWe", 32'(mem_write_enable), 32'd0);
      checkOutput("singleRe", 32'(mem_read_enable), 32'd0);
      checkOutput("singleErr", 32'(err), 32'(refErr));
      checkOutput("singleFlags", 32'(flags), 32'(refFlags));
    end else begin
      for (int p = 1; p <= 3; p++) begin
        @(negedge clk);
        checkOutput("busyReady", 32'(instr_ready), 32'd0);
        checkOutput("phaseWe", 32'(mem_write_enable), 32'(p == 2 && isStore));
        checkOutput("phaseRe", 32'(mem_read_enable), 32'(p == 2 && isLoad));
        checkOutput("phaseRdValid", 32'(rd_valid), 32'(p == 3 && isLoad));
        checkOutput("phaseAddr", 32'(mem_address), 32'(addr));
        checkOutput("phaseData", 32'(mem_data_input), 32'(data));
        if (p == 3 && isLoad) checkOutput("loadData", 32'(rd_data), 32'(refRd));
      end
      @(negedge clk);
      checkOutput("doneReady", 32'(instr_ready), 32'd1);
      checkOutput("doneRdValid", 32'(rd_valid), 32'd0);
    end
    checkOutput("flags", 32'(flags), 32'(refFlags));
    checkOutput("fsel", 32'(alu_function_select), 32'(refFsel));
    checkOutput("err", 32'(err), 32'(refErr));
    checkOutput("rdData", 32'(rd_data), 32'(refRd));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resetRef();
  endtask

  initial begin
    int a0;
    int a1;
    int a2;
    int weBefore;
    int reBefore;
    int rvBefore;
    logic [DATA_W:0] resQ;

    for (int i = 0; i < 32; i++) begin
      benchMem[i] = '0;
      refMem[i]   = '0;
    end

    // Reset state.
    doReset();
    checkOutput("rstReady", 32'(instr_ready), 32'd1);
    checkOutput("rstWe", 32'(mem_write_enable), 32'd0);
    checkOutput("rstRe", 32'(mem_read_enable), 32'd0);
    checkOutput("rstFlags", 32'(flags), 32'd0);
    checkOutput("rstRdValid", 32'(rd_valid), 32'd0);
    checkOutput("rstRdData", 32'(rd_data), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    checkOutput("rstFsel", 32'(alu_function_select), 32'd0);
    checkOutput("rstAddr", 32'(mem_address), 32'd0);
    checkOutput("rstData", 32'(mem_data_input), 32'd0);

    // STORE then LOAD round trip through the bench memory.
    runInstr(OP_STORE, 5'd3, 8'hA5, 9'h000);
    checkOutput("memAddr3", 32'(benchMem[3]), 32'h00A5);
    runInstr(OP_STORE, 5'd7, 8'h5A, 9'h000);
    runInstr(OP_LOAD, 5'd7, 8'h00, 9'h000);
    checkOutput("load7", 32'(rd_data), 32'h005A);

    // Flag corner cases.
    runInstr(OP_ADD, 5'd0, 8'h00, 9'h100);
    checkOutput("addFlags", 32'(flags), 32'b0011);
    runInstr(OP_CMP, 5'd0, 8'h00, 9'h001);
    checkOutput("cmpFlags", 32'(flags), 32'b1000);
    runInstr(OP_NOP, 5'd0, 8'h00, 9'h0FF);
    checkOutput("nopFlags", 32'(flags), 32'b1000);
    runInstr(OP_SUB, 5'd1, 8'h02, 9'h1FF);
    checkOutput("subFlags", 32'(flags), 32'b0101);
    checkOutput("subFsel", 32'(alu_function_select), 32'd1);

    // Illegal opcode is sticky until reset.
    runInstr(OP_ILL, 5'd4, 8'h44, 9'h000);
    checkOutput("illErr", 32'(err), 32'd1);
    runInstr(OP_NOP, 5'd0, 8'h00, 9'h000);
    checkOutput("illErrHeld", 32'(err), 32'd1);
    doReset();
    checkOutput("illErrCleared", 32'(err), 32'd0);

    // Leave nonzero flags behind, then abort a LOAD with reset during STROBE.
    runInstr(OP_INC, 5'd2, 8'h00, 9'h180);
    rvBefore = rvCount;
    alu_result = 9'h000;
    applyStimulus(OP_LOAD, 5'd7, 8'h00, 1'b0, a0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abortInStrobe", 32'(mem_read_enable), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abortWe", 32'(mem_write_enable), 32'd0);
    checkOutput("abortRe", 32'(mem_read_enable), 32'd0);
    checkOutput("abortReady", 32'(instr_ready), 32'd1);
    checkOutput("abortFlags", 32'(flags), 32'd0);
    checkOutput("abortRdValid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resetRef();
    repeat (3) @(negedge clk);
    checkOutput("abortNoPulse", 32'(rvCount - rvBefore), 32'd0);

    // Three queued ops with valid held high throughout.
    resQ = 9'h07F;
    weBefore = weCount;
    reBefore = reCount;
    rvBefore = rvCount;
    alu_result = resQ;
    refApply(OP_STORE, 5'd9, 8'h11, resQ);
    refApply(OP_LOAD, 5'd9, 8'h00, resQ);
    refApply(OP_INC, 5'd2, 8'h00, resQ);
    applyStimulus(OP_STORE, 5'd9, 8'h11, 1'b1, a0);
    applyStimulus(OP_LOAD, 5'd9, 8'h00, 1'b1, a1);
    applyStimulus(OP_INC, 5'd2, 8'h00, 1'b0, a2);
    checkOutput("queueGap1", 32'(a1 - a0), 32'd4);
    checkOutput("queueGap2", 32'(a2 - a1), 32'd4);
    repeat (6) @(negedge clk);
    checkOutput("queueWrites", 32'(weCount - weBefore), 32'd1);
    checkOutput("queueReads", 32'(reCount - reBefore), 32'd1);
    checkOutput("queueRdPulses", 32'(rvCount - rvBefore), 32'd1);
    checkOutput("queueRdData", 32'(rd_data), 32'(refRd));
    checkOutput("queueFlags", 32'(flags), 32'(refFlags));
    checkOutput("queueFsel", 32'(alu_function_select), 32'd3);
    checkOutput("queueReady", 32'(instr_ready), 32'd1);

    // Random instruction mix against the reference model.
    for (int n = 0; n < 40; n++) begin
      runInstr(3'($urandom_range(0, 7)), ADDR_W'($urandom), DATA_W'($urandom),
               (DATA_W + 1)'($urandom));
    end
    for (int i = 0; i < 32; i++) begin
      checkOutput("memImage", 32'(benchMem[i]), 32'(refMem[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_alu_sequencer.md
Name: mem_alu_sequencer

Overview:
- Command sequencer directly upstream of the 32x8 register-file/ALU block.
- Accepts one instruction at a time over a valid/ready handshake and latches it.
- Drives the memory's address, data, write/read strobes and 2-bit ALU function select.
- Captures read data or the ALU result and maintains the 4-bit flag register consumed by that block.

Parameters:
ADDR_W, 5, register-file address width (32 entries)
DATA_W, 8, data/ALU width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  sequencer can accept
instr_op  in  3  opcode
instr_addr  in  ADDR_W  register address (STORE/LOAD)
instr_data  in  DATA_W  write data (STORE)
mem_address  out  ADDR_W  to memory address
mem_data_input  out  DATA_W  to memory data_input
mem_write_enable  out  1  one-cycle write strobe
mem_read_enable  out  1  one-cycle read strobe
mem_output_data  in  DATA_W  memory read data
alu_function_select  out  2  00 ADD, 01 SUB, 10 CMP, 11 INC
alu_result  in  DATA_W+1  ALU result; bit DATA_W is carry/borrow
flags  out  4  flag register
rd_data  out  DATA_W  last LOAD result
rd_valid  out  1  one-cycle pulse, rd_data updated
err  out  1  sticky illegal-opcode indicator

Behaviour:
- Reset: synchronous, sampled on rising clk when rst_n=0.
  - State IDLE.
  - All outputs 0, except instr_ready=1.
  - Reset applied mid-instruction aborts it: strobes low on the same edge, no rd_valid, flags cleared.
- Opcodes: 000 NOP, 001 STORE, 010 LOAD, 011 ADD, 100 SUB, 101 CMP, 110 INC, 111 illegal.
- Accept: instr_valid & instr_ready on a rising edge.
  - op/addr/data are latched on that edge; later input changes are ignored.
  - instr_ready=1 only in IDLE.
- NOP: accepted, state stays IDLE, no outputs change.
- Illegal opcode (111): accepted, err set to 1 (sticky until reset), state stays IDLE, no memory activity.
- Other ops: FSM runs IDLE -> SETUP -> STROBE -> CAPTURE -> IDLE, one cycle per state.
  - instr_ready is low from the accept edge until the CAPTURE->IDLE edge.
  - Throughput is one instruction per 4 cycles.
- SETUP:
  - mem_address and mem_data_input driven from latched fields, held stable through CAPTURE.
  - alu_function_select driven for ALU ops: ADD=00, SUB=01, CMP=10, INC=11.
  - Both strobes low.
- STROBE:
  - STORE: mem_write_enable=1 for exactly one cycle.
  - LOAD: mem_read_enable=1 for exactly one cycle.
  - ALU ops: no strobe; the cycle is settle time.
- CAPTURE:
  - LOAD: rd_data <= mem_output_data; rd_valid=1 for exactly one cycle.
  - ALU op: flags updated from alu_result:
    - flags[0] carry/borrow = alu_result[DATA_W]
    - flags[1] zero = (alu_result[DATA_W-1:0]==0)
    - flags[2] negative = alu_result[DATA_W-1]
    - flags[3] compare true = (op==CMP) & alu_result[0]; cleared by non-CMP ALU ops
  - STORE: no capture.
- Flags hold their value across NOP/STORE/LOAD/illegal ops.
- Strobes are registered outputs, glitch-free, and never both high. Mutual exclusion is asserted in the bench.
- alu_function_select retains its last value outside ALU ops.
- instr_valid may drop or hold while instr_ready=0; no instruction is lost or duplicated.
- Back-to-back valid instructions are accepted on the first IDLE cycle.

Test Plan:
- Reset, then STORE addr=3 data=0xA5 -> mem_write_enable high exactly 2 cycles after accept; mem_address=3 and mem_data_input=0xA5 stable from SETUP through CAPTURE; instr_ready back to 1 at cycle 4.
- STORE 0x5A to addr 7, then LOAD addr 7 (memory model) -> mem_read_enable one-cycle pulse; rd_data=0x5A with rd_valid=1 in cycle 3 after LOAD accept.
- ADD with alu_result=9'h100 -> flags=4'b0011 (carry, zero); then CMP with alu_result=9'h001 -> flags=4'b1000; then NOP -> flags unchanged.
- SUB with alu_result=9'h1FF -> flags[0]=1, flags[2]=1, flags[1]=0, alu_function_select=01.
- Opcode 111 -> accepted in one cycle, err=1, no strobes; following NOP keeps err=1; rst_n=0 clears err.
- LOAD accepted, rst_n=0 during STROBE -> next edge: strobes 0, instr_ready=1, flags=0, no rd_valid; instr_valid held continuously with 3 queued ops -> each accepted exactly once, 4 cycles apart.
